wots_chain_sched: RTL and testbench

Control block that sequences one shared `gen_chain_with_sha` engine over all `WOTS_LEN` chains of a WOTS+ operation: key generation, signing or public-key-from-signature. For each chain it fetches the source value and base-w digit, derives the ADRS chain address and step range, starts the engine or bypasses it, and emits one result write. It sits between the XMSS top-level control and the chain engine and owns no key storage.

---
 rtl/wots_chain_sched_if.sv | 26 ++
 rtl/wots_chain_sched.sv | 151 +++++++++++++++
 tb/tb_wots_chain_sched.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wots_chain_sched_if.sv
// Chain-engine handshake bundle: the scheduler drives the request side
// (start pulse, input value, ADRS, step range) and the engine returns
// its status and result.
interface wots_chain_sched_if #(
  parameter int unsigned LOG_W   = 4,
  parameter int unsigned KEY_LEN = 256
);
  logic               ch_start;
  logic [KEY_LEN-1:0] ch_input_data;
  logic [255:0]       ch_hash_addr;
  logic [LOG_W-1:0]   ch_start_step;
  logic [LOG_W-1:0]   ch_end_step;
  logic               ch_busy;
  logic               ch_done;
  logic [KEY_LEN-1:0] ch_data_out;

  modport master (
    output ch_start, ch_input_data, ch_hash_addr, ch_start_step, ch_end_step,
    input  ch_busy, ch_done, ch_data_out
  );

  modport slave (
    input  ch_start, ch_input_data, ch_hash_addr, ch_start_step, ch_end_step,
    output ch_busy, ch_done, ch_data_out
  );
endinterface

// File: rtl/wots_chain_sched.sv
// WOTS+ chain scheduler: walks all WOTS_LEN chains in ascending order,
// fetches source value and base-w digit, derives the step range for the
// selected operation (PKGEN / SIGN / VERIFY), runs the shared chain engine
// or bypasses it for zero-length chains, and emits one result write per chain.
module wots_chain_sched #(
  parameter int unsigned WOTS_W   = 16,
  parameter int unsigned LOG_W    = 4,
  parameter int unsigned WOTS_LEN = 67,
  parameter int unsigned IDX_W    = 7,
  parameter int unsigned KEY_LEN  = 256
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [1:0]          mode,
  input  logic [255:0]        base_addr,
  output logic [IDX_W-1:0]    src_addr,
  input  logic [KEY_LEN-1:0]  src_data,
  input  logic [LOG_W-1:0]    digit_in,
  wots_chain_sched_if.master  ch,
  output logic                res_we,
  output logic [IDX_W-1:0]    res_addr,
  output logic [KEY_LEN-1:0]  res_data,
  output logic                busy,
  output logic                done
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_ISSUE, S_WAIT, S_WRITE, S_FIN
  } state_t;

  typedef enum logic [1:0] {
    M_PKGEN  = 2'b00,
    M_SIGN   = 2'b01,
    M_VERIFY = 2'b10
  } op_t;

  localparam logic [LOG_W-1:0] STEP_MAX  = LOG_W'(WOTS_W - 2);
  localparam logic [LOG_W-1:0] DIGIT_MAX = LOG_W'(WOTS_W - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WOTS_LEN - 1);
  // ADRS bits replaced per chain: [95:64] chain index, [63:32] hash index
  localparam logic [255:0]     ADRS_MASK = {160'b0, 64'hFFFF_FFFF_FFFF_FFFF, 32'b0};

  state_t             state;
  op_t                op;
  logic [255:0]       base_q;
  logic [IDX_W-1:0]   idx;

  logic [LOG_W-1:0]   ld_start;
  logic [LOG_W-1:0]   ld_end;
  logic               ld_bypass;

  // The external memories and the result port both address by the chain index.
  assign src_addr = idx;
  assign res_addr = idx;

  // Start is issued in the ISSUE cycle the engine reports idle, so the engine
  // latency L counts from this cycle and an engine chain costs 4 + L cycles.
  assign ch.ch_start = (state == S_ISSUE) && !ch.ch_busy;

  // Step range for the chain being loaded, from the digit arriving this cycle.
  always_comb begin
    ld_start  = '0;
    ld_end    = STEP_MAX;
    ld_bypass = 1'b0;
    case (op)
      M_SIGN: begin
        ld_end    = digit_in - LOG_W'(1);
        ld_bypass = (digit_in == '0);
      end
      M_VERIFY: begin
        ld_start  = digit_in;
        ld_bypass = (digit_in == DIGIT_MAX);
      end
      default: ;
    endcase
  end

  // Operation sequencer with registered engine request and result outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= S_IDLE;
      op               <= M_PKGEN;
      base_q           <= '0;
      idx              <= '0;
      ch.ch_input_data <= '0;
      ch.ch_hash_addr  <= '0;
      ch.ch_start_step <= '0;
      ch.ch_end_step   <= '0;
      res_we           <= 1'b0;
      res_data         <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
    end else begin
      res_we <= 1'b0;
      done   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            op     <= (mode == 2'b11) ? M_PKGEN : op_t'(mode);
            base_q <= base_addr;
            idx    <= '0;
            busy   <= 1'b1;
            state  <= S_FETCH;
          end
        end
        S_FETCH: begin
          state <= S_LOAD;
        end
        S_LOAD: begin
          ch.ch_input_data <= src_data;
          ch.ch_hash_addr  <= (base_q & ~ADRS_MASK) | {160'b0, 32'(idx), 64'b0};
          if (ld_bypass) begin
            res_data <= src_data;
            res_we   <= 1'b1;
            state    <= S_WRITE;
          end else begin
            ch.ch_start_step <= ld_start;
            ch.ch_end_step   <= ld_end;
            state            <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!ch.ch_busy) state <= S_WAIT;
        end
        S_WAIT: begin
          if (ch.ch_done) begin
            res_data <= ch.ch_data_out;
            res_we   <= 1'b1;
            state    <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (idx == LAST_IDX) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_FIN;
          end else begin
            idx   <= idx + IDX_W'(1);
            state <= S_FETCH;
          end
        end
        S_FIN: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wots_chain_sched.sv
// Bench for wots_chain_sched with a mock chain engine (latency 20,
// result = input XOR {end_step, start_step}) and a timeline model that
// predicts every start pulse, write and done from the per-chain cost rules.
module tb_wots_chain_sched;
  localparam int unsigned W   = 16;
  localparam int unsigned LW  = 4;
  localparam int          LEN = 4;
  localparam int unsigned IW  = 7;
  localparam int unsigned KL  = 256;
  localparam int          L   = 20;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           start = 1'b0;
  logic [1:0]     mode = 2'b00;
  logic [255:0]   base_addr = '0;
  logic [IW-1:0]  src_addr;
  logic [KL-1:0]  src_data;
  logic [LW-1:0]  digit_in;
  logic           res_we;
  logic [IW-1:0]  res_addr;
  logic [KL-1:0]  res_data;
  logic           busy;
  logic           done;

  wots_chain_sched_if #(.LOG_W(LW), .KEY_LEN(KL)) ch ();

  wots_chain_sched #(
    .WOTS_W(W), .LOG_W(LW), .WOTS_LEN(LEN), .IDX_W(IW), .KEY_LEN(KL)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .base_addr(base_addr),
    .src_addr(src_addr), .src_data(src_data), .digit_in(digit_in), .ch(ch.master),
    .res_we(res_we), .res_addr(res_addr), .res_data(res_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Source and digit memories: one-cycle read latency.
  logic [KL-1:0] mem_src [LEN];
  logic [LW-1:0] mem_dig [LEN];
  always @(posedge clk) begin
    if (int'(src_addr) < LEN) begin
      src_data <= mem_src[src_addr];
      digit_in <= mem_dig[src_addr];
    end
  end

  // Mock engine: done is high L cycles after the cycle that carried ch_start.
  int            eng_due;
  logic [KL-1:0] eng_res;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      eng_due        <= -1;
      ch.ch_done     <= 1'b0;
      ch.ch_data_out <= '0;
    end else begin
      if (ch.ch_start) begin
        eng_due <= cyc + L;
        eng_res <= ch.ch_input_data ^ KL'({ch.ch_end_step, ch.ch_start_step});
      end
      ch.ch_done     <= (cyc + 1 == eng_due);
      ch.ch_data_out <= eng_res;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Model: expected timeline and values per chain, times relative to start cycle.
  int            e_start_t [LEN];
  int            e_we_t    [LEN];
  int            e_done_t;
  logic [KL-1:0] e_res     [LEN];
  logic [LW-1:0] e_st      [LEN];
  logic [LW-1:0] e_en      [LEN];
  logic [255:0]  e_haddr   [LEN];

  task automatic plan(input logic [1:0] m, input logic [255:0] base,
                      input int hold_chain, input int hold_len);
    int b;
    b = 1;
    for (int i = 0; i < LEN; i++) begin
      int d;
      int cnt;
      int st;
      int h;
      d = int'(mem_dig[i]);
      if (m == 2'b01)      begin cnt = d;         st = 0; end
      else if (m == 2'b10) begin cnt = W - 1 - d; st = d; end
      else                 begin cnt = W - 1;     st = 0; end
      e_haddr[i]         = base;
      e_haddr[i][95:64]  = 32'(i);
      e_haddr[i][63:32]  = '0;
      if (cnt == 0) begin
        e_res[i]     = mem_src[i];
        e_start_t[i] = -1;
        e_we_t[i]    = b + 2;
        e_st[i]      = '0;
        e_en[i]      = '0;
        b            = b + 3;
      end else begin
        h            = (i == hold_chain) ? hold_len : 0;
        e_st[i]      = LW'(st);
        e_en[i]      = LW'(st + cnt - 1);
        e_res[i]     = mem_src[i] ^ KL'({e_en[i], e_st[i]});
        e_start_t[i] = b + 2 + h;
        e_we_t[i]    = e_start_t[i] + L + 1;
        b            = e_we_t[i] + 1;
      end
    end
    e_done_t = b;
  endtask

  // Observed event record, used to pin the model with literal expectations.
  int            o_start_t [LEN];
  int            o_we_t    [LEN];
  int            o_done_t;
  int            o_starts;
  logic [LW-1:0] o_st      [LEN];
  logic [LW-1:0] o_en      [LEN];
  logic [KL-1:0] o_res     [LEN];

  bit armed = 1'b0;
  int t0;

  always @(negedge clk) begin : cmp
    int t;
    int wi;
    int k;
    bit exp_start;
    bit exp_we;
    if (armed) begin
      t = cyc - t0;
      chk("busy", busy, (t >= 1) && (t < e_done_t));
      chk("done", done, t == e_done_t);
      exp_start = 1'b0;
      exp_we    = 1'b0;
      wi        = 0;
      for (int i = 0; i < LEN; i++) begin
        if (e_start_t[i] == t) exp_start = 1'b1;
        if (e_we_t[i] == t) begin exp_we = 1'b1; wi = i; end
      end
      chk("ch_start", ch.ch_start, exp_start);
      chk("res_we", res_we, exp_we);
      if (exp_we) begin
        chk("res_addr", res_addr, wi);
        chk("res_data", res_data, e_res[wi]);
      end
      for (int i = 0; i < LEN; i++) begin
        if (e_start_t[i] >= 0 && t >= e_start_t[i] && t < e_we_t[i]) begin
          chk("ch_hash_addr", ch.ch_hash_addr, e_haddr[i]);
          chk("ch_start_step", ch.ch_start_step, e_st[i]);
          chk("ch_end_step", ch.ch_end_step, e_en[i]);
          chk("ch_input_data", ch.ch_input_data, mem_src[i]);
        end
      end
      if (ch.ch_start) begin
        k = int'(ch.ch_hash_addr[95:64]);
        o_starts++;
        if (k >= 0 && k < LEN) begin
          o_start_t[k] = t;
          o_st[k]      = ch.ch_start_step;
          o_en[k]      = ch.ch_end_step;
        end
      end
      if (res_we && int'(res_addr) < LEN) begin
        o_we_t[res_addr] = t;
        o_res[res_addr]  = res_data;
      end
      if (done) o_done_t = t;
    end
  end

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_src_addr"}, src_addr, 0);
    chk({tag, "_ch_start"}, ch.ch_start, 0);
    chk({tag, "_ch_input_data"}, ch.ch_input_data, 0);
    chk({tag, "_ch_hash_addr"}, ch.ch_hash_addr, 0);
    chk({tag, "_ch_start_step"}, ch.ch_start_step, 0);
    chk({tag, "_ch_end_step"}, ch.ch_end_step, 0);
    chk({tag, "_res_we"}, res_we, 0);
    chk({tag, "_res_addr"}, res_addr, 0);
    chk({tag, "_res_data"}, res_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  // extra_t: cycle of a spurious start (-2 = the FIN cycle); abort_t: reset cycle.
  task automatic run_op(input logic [1:0] m, input logic [255:0] base,
                        input int hold_chain, input int hold_len,
                        input int extra_t, input int abort_t);
    int issue_t;
    plan(m, base, hold_chain, hold_len);
    issue_t = (hold_chain >= 0) ? e_start_t[hold_chain] - hold_len : -1;
    for (int i = 0; i < LEN; i++) begin
      o_start_t[i] = -1;
      o_we_t[i]    = -1;
    end
    o_done_t = -1;
    o_starts = 0;
    @(posedge clk); #1;
    start     = 1'b1;
    mode      = m;
    base_addr = base;
    t0        = cyc;
    armed     = 1'b1;
    for (int k = 1; k <= e_done_t + 1; k++) begin
      @(posedge clk); #1;
      start     = (k == extra_t) || (extra_t == -2 && k == e_done_t);
      mode      = m ^ 2'b01;
      base_addr = ~base;
      if (k == issue_t)            ch.ch_busy = 1'b1;
      if (k == issue_t + hold_len) ch.ch_busy = 1'b0;
      if (k == abort_t) begin
        armed = 1'b0;
        reset = 1'b0;
        #1;
        check_outputs_zero("abort");
        return;
      end
    end
    @(negedge clk); #1;
    armed = 1'b0;
  endtask

  logic [255:0] base_a;
  logic [255:0] base_b;

  initial begin
    ch.ch_busy = 1'b0;
    base_a = {8{32'hDEAD_BEEF}};
    base_b = {4{64'h0123_4567_89AB_CDEF}};
    for (int i = 0; i < LEN; i++) begin
      mem_src[i] = KL'(i);
      mem_dig[i] = '0;
    end

    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #1;
    reset = 1'b1;

    // PKGEN, src[i] = i
    mem_dig[0] = 4'd3; mem_dig[1] = 4'd9; mem_dig[2] = 4'd0; mem_dig[3] = 4'd15;
    run_op(2'b00, base_a, -1, 0, -1, -1);
    chk("pk_done_t", o_done_t, 97);
    chk("pk_we_t0", o_we_t[0], 24);
    chk("pk_res0", o_res[0], 256'h0E0);
    chk("pk_res1", o_res[1], 256'h0E1);
    chk("pk_res3", o_res[3], 256'h0E3);
    chk("pk_end1", o_en[1], 14);

    // SIGN, digits {0,15,3,1}
    for (int i = 0; i < LEN; i++) mem_src[i] = {8{32'hA5A5_0000 | 32'(i)}};
    mem_dig[0] = 4'd0; mem_dig[1] = 4'd15; mem_dig[2] = 4'd3; mem_dig[3] = 4'd1;
    run_op(2'b01, base_b, -1, 0, -1, -1);
    chk("sg_we_t0", o_we_t[0], 3);
    chk("sg_res0", o_res[0], {8{32'hA5A5_0000}});
    chk("sg_starts", o_starts, 3);
    chk("sg_end1", o_en[1], 14);
    chk("sg_end2", o_en[2], 2);
    chk("sg_end3", o_en[3], 0);
    chk("sg_done_t", o_done_t, 76);

    // VERIFY, digits {15,0,7,14}
    mem_dig[0] = 4'd15; mem_dig[1] = 4'd0; mem_dig[2] = 4'd7; mem_dig[3] = 4'd14;
    run_op(2'b10, base_a, -1, 0, -1, -1);
    chk("vf_starts", o_starts, 3);
    chk("vf_st1", o_st[1], 0);
    chk("vf_st2", o_st[2], 7);
    chk("vf_st3", o_st[3], 14);
    chk("vf_end3", o_en[3], 14);
    chk("vf_done_t", o_done_t, 76);

    // Engine busy for 10 cycles at chain 2, spurious start mid-operation
    for (int i = 0; i < LEN; i++) mem_src[i] = KL'(i);
    run_op(2'b00, base_b, 2, 10, 40, -1);
    chk("hold_start_t2", o_start_t[2], 61);
    chk("hold_done_t", o_done_t, 107);

    // Mode 11 behaves as PKGEN; a start in the FIN cycle is ignored
    run_op(2'b11, base_a, -1, 0, -2, -1);
    chk("m3_done_t", o_done_t, 97);
    chk("m3_res2", o_res[2], 256'h0E2);

    // Reset during WAIT of chain 1, then a clean run
    run_op(2'b00, base_a, -1, 0, -1, 35);
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      chk("post_abort_done", done, 0);
      chk("post_abort_res_we", res_we, 0);
      chk("post_abort_busy", busy, 0);
    end
    run_op(2'b00, base_b, -1, 0, -1, -1);
    chk("rerun_we_t0", o_we_t[0], 24);
    chk("rerun_done_t", o_done_t, 97);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
